aes_block_fifo: RTL and testbench

//  Input buffer directly upstream of aes_decryption. Packs 32-bit host words into 128-bit AES blocks.

---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_block_fifo_if.sv | 28 ++
 rtl/aes_word_packer.sv | 36 +++
 rtl/aes_block_fifo.sv | 83 ++++++++
 tb/tb_aes_block_fifo.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants for the host-side input buffer.
package aes_pkg;
  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = AES_BLOCK_W / AES_WORD_W;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [$clog2(AES_WORDS_PER_BLOCK)-1:0] word_idx_t;

  // One host word offered to the packer; valid is already qualified by the handshake.
  typedef struct packed {
    logic                  valid;
    logic [AES_WORD_W-1:0] data;
  } aes_word_req_t;
endpackage

// File: rtl/aes_block_fifo_if.sv
// Host word handshake plus block-side FWFT signals between host, buffer and aes_decryption.
interface aes_block_fifo_if #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
);
  import aes_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic [WORD_W-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             read_fifo;
  aes_block_t       fifo_out;
  logic             is_full;
  logic [CNT_W-1:0] block_count;
  logic             underflow;

  modport master (
    output flush, word_in, word_valid, read_fifo,
    input  word_ready, fifo_out, is_full, block_count, underflow
  );

  modport slave (
    input  flush, word_in, word_valid, read_fifo,
    output word_ready, fifo_out, is_full, block_count, underflow
  );
endinterface

// File: rtl/aes_word_packer.sv
// Gathers four host words into one block; word 0 ends up in the top lane.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  aes_word_req_t req,
  output word_idx_t     word_cnt,
  output logic          block_valid,
  output aes_block_t    block
);
  localparam int LANES = AES_WORDS_PER_BLOCK - 1;

  // Ascending lane index so lane 0 is the most significant word of the block.
  logic [0:LANES-1][AES_WORD_W-1:0] partial_q;
  word_idx_t                        cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      partial_q <= '0;
    end else if (flush) begin
      cnt_q     <= '0;
      partial_q <= '0;
    end else if (req.valid) begin
      cnt_q <= cnt_q + 1'b1;
      for (int i = 0; i < LANES; i++)
        if (cnt_q == word_idx_t'(i)) partial_q[i] <= req.data;
    end
  end

  assign word_cnt    = cnt_q;
  assign block_valid = req.valid && (cnt_q == word_idx_t'(LANES));
  assign block       = {partial_q, req.data};
endmodule

// File: rtl/aes_block_fifo.sv
// Block FIFO feeding aes_decryption: packs host words, stores DEPTH blocks, FWFT head output.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  aes_block_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (WORD_W != AES_WORD_W) begin : g_bad_word_w
    $error("aes_block_fifo: WORD_W must equal AES_BLOCK_W/4");
  end

  aes_block_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uf_q;

  word_idx_t        word_cnt;
  logic             commit;
  aes_block_t       packed_blk;
  aes_word_req_t    req;
  logic             take, pop, empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Ready only looks at registered state, so a pop cannot combinationally open the slot.
  assign bus.word_ready = !((word_cnt == word_idx_t'(AES_WORDS_PER_BLOCK - 1)) && full);
  assign take           = bus.word_valid && bus.word_ready;
  assign pop            = bus.read_fifo && !empty;

  assign req.valid = take && !bus.flush;
  assign req.data  = bus.word_in;

  aes_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .flush       (bus.flush),
    .req         (req),
    .word_cnt    (word_cnt),
    .block_valid (commit),
    .block       (packed_blk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      uf_q     <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      uf_q     <= 1'b0;
    end else begin
      if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.read_fifo && empty) uf_q <= 1'b1;
      case ({commit, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is never reset; the head mux forces zero whenever nothing is stored.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr_q] <= packed_blk;
  end

  assign bus.fifo_out    = empty ? '0 : mem[rd_ptr_q];
  assign bus.is_full     = !empty;
  assign bus.block_count = cnt_q;
  assign bus.underflow   = uf_q;
endmodule

// File: tb/tb_aes_block_fifo.sv
// Self-checking bench for aes_block_fifo: vector table, directed corner sequences, random vs queue model.
module tb_aes_block_fifo;
  localparam int DEPTH = 4;

  logic tb_clk = 1'b0;
  logic rst    = 1'b0;
  always #5 tb_clk = ~tb_clk;

  aes_block_fifo_if #(.WORD_W(32), .DEPTH(DEPTH)) bus ();
  aes_block_fifo #(.WORD_W(32), .DEPTH(DEPTH)) dut (.clk(tb_clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a queue of whole blocks plus the list of words of the block in progress.
  logic [31:0]  m_part[$];
  logic [127:0] m_blk[$];
  bit           m_uf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit m_ready();
    return !(m_part.size() == 3 && m_blk.size() == DEPTH);
  endfunction

  task automatic m_clear();
    m_part.delete(); m_blk.delete(); m_uf = 0;
  endtask

  task automatic model_edge(input bit wv, input logic [31:0] w, input bit rf, input bit fl);
    bit rdy, pop;
    rdy = m_ready();
    pop = rf && (m_blk.size() != 0);
    if (fl) m_clear();
    else begin
      if (rf && m_blk.size() == 0) m_uf = 1;
      if (pop) void'(m_blk.pop_front());
      if (wv && rdy) begin
        m_part.push_back(w);
        if (m_part.size() == 4) begin
          m_blk.push_back({m_part[0], m_part[1], m_part[2], m_part[3]});
          m_part.delete();
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/is_full"}, 128'(bus.is_full), 128'(m_blk.size() != 0));
    chk({tag, "/count"}, 128'(bus.block_count), 128'(m_blk.size()));
    chk({tag, "/ready"}, 128'(bus.word_ready), 128'(m_ready()));
    chk({tag, "/uf"}, 128'(bus.underflow), 128'(m_uf));
    chk({tag, "/out"}, bus.fifo_out, (m_blk.size() != 0) ? m_blk[0] : 128'h0);
  endtask

  // Inputs change 1 time unit after a rising edge and outputs are read there too.
  task automatic step(input bit wv, input logic [31:0] w, input bit rf, input bit fl);
    bus.word_valid = wv; bus.word_in = w; bus.read_fifo = rf; bus.flush = fl;
    model_edge(wv, w, rf, fl);
    @(posedge tb_clk); #1;
    bus.word_valid = 0; bus.read_fifo = 0; bus.flush = 0;
  endtask

  function automatic logic [31:0] wd(input int b, input int k);
    return 32'hB000_0000 | 32'(b << 8) | 32'(k);
  endfunction

  function automatic logic [127:0] blk_of(input int b);
    return {wd(b, 0), wd(b, 1), wd(b, 2), wd(b, 3)};
  endfunction

  typedef struct {
    bit           wv;
    logic [31:0]  w;
    bit           rf;
    bit           fl;
    bit           e_full;
    int           e_cnt;
    bit           e_ready;
    bit           e_uf;
    logic [127:0] e_out;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{1, 32'h00112233, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[1]  = '{1, 32'h44556677, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[2]  = '{1, 32'h8899aabb, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[3]  = '{1, 32'hccddeeff, 0, 0, 1, 1, 1, 0, 128'h00112233_44556677_8899aabb_ccddeeff};
    vt[4]  = '{0, 32'h0,        1, 0, 0, 0, 1, 0, 128'h0};
    vt[5]  = '{0, 32'h0,        1, 0, 0, 0, 1, 1, 128'h0};
    vt[6]  = '{1, 32'haaaa0000, 0, 0, 0, 0, 1, 1, 128'h0};
    vt[7]  = '{1, 32'hbbbb1111, 0, 0, 0, 0, 1, 1, 128'h0};
    vt[8]  = '{1, 32'hdeadbeef, 1, 1, 0, 0, 1, 0, 128'h0};
    vt[9]  = '{1, 32'h11111111, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[10] = '{1, 32'h22222222, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[11] = '{1, 32'h33333333, 0, 0, 0, 0, 1, 0, 128'h0};
    vt[12] = '{1, 32'h44444444, 0, 0, 1, 1, 1, 0, 128'h11111111_22222222_33333333_44444444};
    vt[13] = '{0, 32'h0,        1, 0, 0, 0, 1, 0, 128'h0};

    bus.word_valid = 0; bus.word_in = '0; bus.read_fifo = 0; bus.flush = 0;
    m_clear();

    // Asynchronous reset observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst0/is_full", 128'(bus.is_full), 128'h0);
    chk("rst0/count", 128'(bus.block_count), 128'h0);
    chk("rst0/out", bus.fifo_out, 128'h0);
    chk("rst0/ready", 128'(bus.word_ready), 128'h1);
    chk("rst0/uf", 128'(bus.underflow), 128'h0);
    #9 rst = 1'b0;
    @(posedge tb_clk); #1;

    // Single block, pop, underflow, flush-overrides-transfer, repacking after flush.
    for (int i = 0; i < 14; i++) begin
      step(vt[i].wv, vt[i].w, vt[i].rf, vt[i].fl);
      chk($sformatf("vec%0d/is_full", i), 128'(bus.is_full), 128'(vt[i].e_full));
      chk($sformatf("vec%0d/count", i), 128'(bus.block_count), 128'(vt[i].e_cnt));
      chk($sformatf("vec%0d/ready", i), 128'(bus.word_ready), 128'(vt[i].e_ready));
      chk($sformatf("vec%0d/uf", i), 128'(bus.underflow), 128'(vt[i].e_uf));
      chk($sformatf("vec%0d/out", i), bus.fifo_out, vt[i].e_out);
    end

    // Fill to DEPTH, hold the fourth word of the next block, release it with one pop.
    step(0, 0, 0, 1);
    for (int b = 0; b < DEPTH; b++)
      for (int k = 0; k < 4; k++) step(1, wd(b, k), 0, 0);
    chk("fill/count", 128'(bus.block_count), 128'(DEPTH));
    for (int k = 0; k < 3; k++) step(1, wd(4, k), 0, 0);
    chk("fill/w012_accepted_ready", 128'(bus.word_ready), 128'h0);
    step(1, wd(4, 3), 0, 0);
    chk("fill/held_count", 128'(bus.block_count), 128'(DEPTH));
    chk("fill/held_ready", 128'(bus.word_ready), 128'h0);
    step(1, wd(4, 3), 1, 0);
    chk("fill/pop_count", 128'(bus.block_count), 128'(DEPTH - 1));
    chk("fill/pop_ready", 128'(bus.word_ready), 128'h1);
    step(1, wd(4, 3), 0, 0);
    chk("fill/commit_count", 128'(bus.block_count), 128'(DEPTH));
    check_model("fill");
    for (int b = 1; b <= DEPTH; b++) begin
      chk($sformatf("fill/order%0d", b), bus.fifo_out, blk_of(b));
      step(0, 0, 1, 0);
    end
    chk("fill/drained", 128'(bus.is_full), 128'h0);
    chk("fill/drained_out", bus.fifo_out, 128'h0);

    // Commit and pop on the same edge with one block stored.
    for (int k = 0; k < 4; k++) step(1, wd(5, k), 0, 0);
    for (int k = 0; k < 3; k++) step(1, wd(6, k), 0, 0);
    chk("sim/head_before", bus.fifo_out, blk_of(5));
    step(1, wd(6, 3), 1, 0);
    chk("sim/count", 128'(bus.block_count), 128'h1);
    chk("sim/head_after", bus.fifo_out, blk_of(6));
    check_model("sim");

    // Reset asserted mid-cycle and mid-block; the next word must be word 0.
    step(1, wd(7, 0), 0, 0);
    step(1, wd(7, 1), 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst1/is_full", 128'(bus.is_full), 128'h0);
    chk("rst1/count", 128'(bus.block_count), 128'h0);
    chk("rst1/out", bus.fifo_out, 128'h0);
    m_clear();
    #2 rst = 1'b0;
    @(posedge tb_clk); #1;
    for (int k = 0; k < 4; k++) step(1, wd(8, k), 0, 0);
    chk("rst1/repack", bus.fifo_out, blk_of(8));
    step(0, 0, 1, 0);

    // Random traffic against the model; pop pressure changes between phases.
    for (int i = 0; i < 600; i++) begin
      bit wv, rf, fl;
      wv = ($urandom_range(0, 3) != 0);
      rf = (i < 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      fl = ($urandom_range(0, 60) == 0);
      step(wv, $urandom, rf, fl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
